// File: rtl/ir_rx_fifo.sv
// Capture stage after the IR NEC decoder: frame FIFO, ir_int_clr handshake, repeat counter, sticky overflow, level irq.
// Entry visible one edge after ir_int; full FIFO drops the frame and sets ovf. Optional IR_RX_FIFO_REPEAT_PUSH_EN also pushes repeat frames.
module ir_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ir_int,
  input  logic [31:0]   ir_data,
  input  logic          ir_repeat,
  input  logic          ir_cmp_err,
  output logic          ir_int_clr,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          rd_err,
  output logic          rd_rep,
  output logic [AW:0]   fifo_cnt,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [7:0]    rep_cnt,
  input  logic          rep_clr,
  input  logic [AW:0]   rf_irq_th,
  input  logic          rf_irq_mask,
  output logic          irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_LOW
  } state_t;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rep_cnt_q, rep_cnt_d;
  logic          irq_q, irq_d;

  logic [32:0]   mem_q [DEPTH];
`ifdef IR_RX_FIFO_REPEAT_PUSH_EN
  logic          rep_mem_q [DEPTH];
`endif

  logic          frame_act;
  logic          push_req;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_set;
  logic          empty;
  logic          full;
  logic [AW:0]   th_eff;

  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == CNT_FULL);
    frame_act = (state_q == ST_IDLE) && ir_int;
`ifdef IR_RX_FIFO_REPEAT_PUSH_EN
    push_req  = frame_act;
`else
    push_req  = frame_act && !ir_repeat;
`endif
    pop_ok    = rd_en && !empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    push_ok   = push_req && (!full || pop_ok);
    ovf_set   = push_req && full && !pop_ok;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (ir_int) state_d = ST_CLEAR;
      ST_CLEAR:    state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!ir_int) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    rep_cnt_d = rep_cnt_q;
    if (frame_act && !ir_repeat) begin
      rep_cnt_d = 8'd0;
    end else if (frame_act && ir_repeat) begin
      // Clear and increment together count this repeat as the first one.
      if (rep_clr)                 rep_cnt_d = 8'd1;
      else if (rep_cnt_q != 8'hFF) rep_cnt_d = rep_cnt_q + 8'd1;
    end else if (rep_clr) begin
      rep_cnt_d = 8'd0;
    end

    th_eff = (rf_irq_th == '0) ? CNT_ONE : rf_irq_th;
    irq_d  = !rf_irq_mask && ((cnt_q >= th_eff) || ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rep_cnt_q <= 8'd0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rep_cnt_q <= rep_cnt_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {ir_cmp_err, ir_data};
`ifdef IR_RX_FIFO_REPEAT_PUSH_EN
      rep_mem_q[wr_ptr_q] <= ir_repeat;
`endif
    end
  end

  // Head is masked while empty so stale or uninitialised slots never leak out.
  always_comb begin
    ir_int_clr = (state_q == ST_CLEAR);
    rd_data    = empty ? 32'd0 : mem_q[rd_ptr_q][31:0];
    rd_err     = empty ? 1'b0  : mem_q[rd_ptr_q][32];
`ifdef IR_RX_FIFO_REPEAT_PUSH_EN
    rd_rep     = empty ? 1'b0  : rep_mem_q[rd_ptr_q];
`else
    rd_rep     = 1'b0;
`endif
    fifo_cnt   = cnt_q;
    fifo_empty = empty;
    fifo_full  = full;
    ovf        = ovf_q;
    rep_cnt    = rep_cnt_q;
    irq        = irq_q;
  end

endmodule

// File: tb/tb_ir_rx_fifo.sv
// Directed bench for ir_rx_fifo: handshake, overflow, full-FIFO push/pop, repeat counting, irq masking, reset mid-frame.
module tb_ir_rx_fifo;

`ifdef IR_RX_FIFO_REPEAT_PUSH_EN
  localparam int REP_PUSH = 1;
`else
  localparam int REP_PUSH = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_int;
  logic [31:0] ir_data;
  logic        ir_repeat;
  logic        ir_cmp_err;
  logic        ir_int_clr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        rd_rep;
  logic [2:0]  fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  rep_cnt;
  logic        rep_clr;
  logic [2:0]  rf_irq_th;
  logic        rf_irq_mask;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  ir_rx_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ir_int     (ir_int),
    .ir_data    (ir_data),
    .ir_repeat  (ir_repeat),
    .ir_cmp_err (ir_cmp_err),
    .ir_int_clr (ir_int_clr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .rd_rep     (rd_rep),
    .fifo_cnt   (fifo_cnt),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .rep_cnt    (rep_cnt),
    .rep_clr    (rep_clr),
    .rf_irq_th  (rf_irq_th),
    .rf_irq_mask(rf_irq_mask),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One decoder frame: ir_int high for two edges, dropped before the third.
  task automatic frame(input logic [31:0] d, input logic e, input logic r,
                       input logic pop, input logic oclr, input logic rclr);
    ir_int = 1'b1; ir_data = d; ir_cmp_err = e; ir_repeat = r;
    rd_en = pop; ovf_clr = oclr; rep_clr = rclr;
    tick();
    rd_en = 1'b0; ovf_clr = 1'b0; rep_clr = 1'b0;
    chk("clr_pulse", {31'd0, ir_int_clr}, 32'd1);
    tick();
    chk("clr_low", {31'd0, ir_int_clr}, 32'd0);
    ir_int = 1'b0;
    tick();
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d, input logic e);
    chk(tag, rd_data, d);
    chk({tag, "_err"}, {31'd0, rd_err}, {31'd0, e});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ir_int = 1'b0; ir_data = '0; ir_repeat = 1'b0; ir_cmp_err = 1'b0;
    rd_en = 1'b0; ovf_clr = 1'b0; rep_clr = 1'b0; rf_irq_th = 3'd1; rf_irq_mask = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cnt",   {29'd0, fifo_cnt}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_full",  {31'd0, fifo_full}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf}, 32'd0);
    chk("rst_rep",   {24'd0, rep_cnt}, 32'd0);
    chk("rst_clr",   {31'd0, ir_int_clr}, 32'd0);
    chk("rst_irq",   {31'd0, irq}, 32'd0);
    chk("rst_data",  rd_data, 32'd0);

    // Single full frame, checked edge by edge
    ir_int = 1'b1; ir_data = 32'h00FF_30CF; ir_cmp_err = 1'b0; ir_repeat = 1'b0;
    tick();
    chk("s_clr",  {31'd0, ir_int_clr}, 32'd1);
    chk("s_cnt",  {29'd0, fifo_cnt}, 32'd1);
    chk("s_data", rd_data, 32'h00FF_30CF);
    chk("s_err",  {31'd0, rd_err}, 32'd0);
    chk("s_irq0", {31'd0, irq}, 32'd0);
    tick();
    chk("s_clr_lo", {31'd0, ir_int_clr}, 32'd0);
    chk("s_irq1",   {31'd0, irq}, 32'd1);
    ir_int = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("s_empty", {31'd0, fifo_empty}, 32'd1);
    tick();
    chk("s_irq_off", {31'd0, irq}, 32'd0);

    // Overflow: five frames into four slots
    for (int i = 1; i <= 5; i++) frame(i, (i == 3), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("o_full", {31'd0, fifo_full}, 32'd1);
    chk("o_cnt",  {29'd0, fifo_cnt}, 32'd4);
    chk("o_ovf",  {31'd0, ovf}, 32'd1);
    pop_expect("o_pop1", 32'd1, 1'b0);
    pop_expect("o_pop2", 32'd2, 1'b0);
    pop_expect("o_pop3", 32'd3, 1'b1);
    pop_expect("o_pop4", 32'd4, 1'b0);
    chk("o_empty", {31'd0, fifo_empty}, 32'd1);
    chk("o_ovf_sticky", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("o_ovf_clr", {31'd0, ovf}, 32'd0);

    // Push and pop together while full
    for (int i = 1; i <= 4; i++) frame(i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(32'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("f_cnt", {29'd0, fifo_cnt}, 32'd4);
    chk("f_ovf", {31'd0, ovf}, 32'd0);
    pop_expect("f_pop2", 32'd2, 1'b0);
    pop_expect("f_pop3", 32'd3, 1'b0);
    pop_expect("f_pop4", 32'd4, 1'b0);
    pop_expect("f_pop5", 32'd5, 1'b0);
    chk("f_empty", {31'd0, fifo_empty}, 32'd1);

    // Repeat counting
    for (int i = 0; i < 300; i++) frame(32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("r_sat", {24'd0, rep_cnt}, 32'd255);
    if (REP_PUSH != 0) begin
      chk("r_cnt_push", {29'd0, fifo_cnt}, 32'd4);
      chk("r_rep_tag", {31'd0, rd_rep}, 32'd1);
      for (int i = 0; i < 4; i++) pop_expect("r_rep_pop", 32'd5, 1'b0);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    end else begin
      chk("r_cnt_nopush", {29'd0, fifo_cnt}, 32'd0);
      chk("r_rep_tied", {31'd0, rd_rep}, 32'd0);
    end
    frame(32'hAAAA_5555, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r_full_clr", {24'd0, rep_cnt}, 32'd0);
    chk("r_full_rep", {31'd0, rd_rep}, 32'd0);
    frame(32'hAAAA_5555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("r_clr_inc", {24'd0, rep_cnt}, 32'd1);
    rep_clr = 1'b1; tick(); rep_clr = 1'b0;
    chk("r_clr_only", {24'd0, rep_cnt}, 32'd0);
    pop_expect("r_pop_full", 32'hAAAA_5555, 1'b1);
    if (REP_PUSH != 0) pop_expect("r_pop_rep", 32'hAAAA_5555, 1'b0);
    chk("r_empty", {31'd0, fifo_empty}, 32'd1);

    // Empty pop must not move pointers
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("e_cnt", {29'd0, fifo_cnt}, 32'd0);
    frame(32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("e_head", rd_data, 32'h0000_0011);
    frame(32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rf_irq_mask = 1'b1; tick(); tick();
    chk("m_masked", {31'd0, irq}, 32'd0);
    rf_irq_mask = 1'b0; tick();
    chk("m_unmasked", {31'd0, irq}, 32'd1);
    pop_expect("m_pop", 32'h0000_0011, 1'b0);
    rf_irq_th = 3'd2; tick(); tick();
    chk("t_below", {31'd0, irq}, 32'd0);
    rf_irq_th = 3'd0; tick();
    chk("t_zero", {31'd0, irq}, 32'd1);
    rf_irq_th = 3'd1;
    pop_expect("m_pop2", 32'h0000_0022, 1'b0);

    // Reset while in CLEAR with ir_int still high
    ir_int = 1'b1; ir_data = 32'h0000_0033; ir_repeat = 1'b0; ir_cmp_err = 1'b0;
    tick();
    chk("x_clear", {31'd0, ir_int_clr}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("x_cnt0", {29'd0, fifo_cnt}, 32'd0);
    chk("x_clr0", {31'd0, ir_int_clr}, 32'd0);
    tick();
    chk("x_cnt1", {29'd0, fifo_cnt}, 32'd1);
    chk("x_clr1", {31'd0, ir_int_clr}, 32'd1);
    tick();
    chk("x_clr_lo", {31'd0, ir_int_clr}, 32'd0);
    ir_int = 1'b0; tick();
    chk("x_data", rd_data, 32'h0000_0033);

    // Clearing ovf in the same cycle as a new overflow keeps it set
    for (int i = 0; i < 3; i++) frame(32'h40 + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p_ovf_pre", {31'd0, ovf}, 32'd0);
    frame(32'h0000_0050, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("p_ovf_win", {31'd0, ovf}, 32'd1);
    chk("p_head", rd_data, 32'h0000_0033);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
